// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite RAM writer.
//   - MMIO register offsets (PIXEL, RECT, STATUS, CTRL)
//   - command word field positions
//   - FSM state enum
//   - sprite side length / coordinate width
package sprite_pkg;

  localparam int unsigned SPRITE_SIDE = 32;
  localparam int unsigned COORD_W     = 5;

  localparam logic [4:0] OFF_PIXEL  = 5'd0;
  localparam logic [4:0] OFF_RECT   = 5'd1;
  localparam logic [4:0] OFF_STATUS = 5'd2;
  localparam logic [4:0] OFF_CTRL   = 5'd3;

  // Field LSBs; x/y share positions between PIXEL and RECT words.
  localparam int unsigned F_X_LSB        = 0;
  localparam int unsigned F_Y_LSB        = 5;
  localparam int unsigned F_PIX_COL_LSB  = 10;
  localparam int unsigned F_W_LSB        = 10;
  localparam int unsigned F_H_LSB        = 15;
  localparam int unsigned F_RECT_COL_LSB = 20;
  localparam int unsigned COL_W          = 2;

  localparam int unsigned CTRL_ABORT_BIT   = 0;
  localparam int unsigned CTRL_CLR_ERR_BIT = 1;

  typedef enum logic [1:0] {
    StIdle,
    StPix,
    StRect
  } state_e;

endpackage

// File: rtl/sprite_rect_scan.sv
// sprite_rect_scan: raster offset counter for rectangle fills.
// Holds the offset (i, j) of the pixel currently being emitted; x fastest.
//   clk, reset   : clock, synchronous active-high reset
//   i_load       : restart at (0,0) and capture width-1 / height-1
//   i_step       : advance to the next offset in raster order
//   i_w_m1/i_h_m1: rectangle width-1 / height-1
//   o_done       : current offset is the last pixel of the rectangle
//   o_x / o_y    : offset of the next pixel in raster order
module sprite_rect_scan
  import sprite_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [COORD_W-1:0] i_w_m1,
  input  logic [COORD_W-1:0] i_h_m1,
  output logic               o_done,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y
);

  logic [COORD_W-1:0] r_i, r_j, r_w_m1, r_h_m1;
  logic               w_last_x;

  assign w_last_x = (r_i == r_w_m1);
  assign o_done   = w_last_x && (r_j == r_h_m1);
  assign o_x      = w_last_x ? '0 : r_i + COORD_W'(1);
  assign o_y      = w_last_x ? r_j + COORD_W'(1) : r_j;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_i    <= '0;
      r_j    <= '0;
      r_w_m1 <= '0;
      r_h_m1 <= '0;
    end else if (i_load) begin
      r_i    <= '0;
      r_j    <= '0;
      r_w_m1 <= i_w_m1;
      r_h_m1 <= i_h_m1;
    end else if (i_step) begin
      r_i <= o_x;
      r_j <= o_y;
    end
  end

endmodule

// File: rtl/sprite_ram_writer.sv
// sprite_ram_writer: MMIO slave that writes single pixels or filled
// rectangles into a sprite RAM, one pixel per cycle.
//   clk, reset          : clock, synchronous active-high reset
//   cs, read, write     : bus slot select and strobes
//   addr, wr_data       : register offset and write data
//   rd_data             : STATUS {30'b0, err, busy} at offset 2, else 0
//   we, addr_w, din     : sprite RAM write port, addr_w = {y, x}
// Build option: define SPRITE_WR_CLIP_EN to suppress writes for rectangle
// pixels past column/row 31 instead of wrapping modulo 32.
module sprite_ram_writer
  import sprite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  read,
  input  logic                  write,
  input  logic [4:0]            addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [DATA_WIDTH-1:0] din
);

  state_e                r_state;
  logic                  r_we;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic [COORD_W-1:0]    r_x0, r_y0;

  logic               w_wr, w_cmd_pix, w_cmd_rect, w_abort, w_clr_err, w_busy;
  logic               w_load, w_step, w_scan_done, w_pix_on;
  logic [COORD_W-1:0] w_off_x, w_off_y;
  logic [COORD_W:0]   w_sum_x, w_sum_y;
  logic               w_unused_wdata;

  assign w_wr       = cs && write;
  assign w_cmd_pix  = w_wr && (addr == OFF_PIXEL);
  assign w_cmd_rect = w_wr && (addr == OFF_RECT);
  assign w_abort    = w_wr && (addr == OFF_CTRL) && wr_data[CTRL_ABORT_BIT];
  assign w_clr_err  = w_wr && (addr == OFF_CTRL) && wr_data[CTRL_CLR_ERR_BIT];
  assign w_busy     = (r_state != StIdle);

  assign w_load = w_cmd_rect && !w_busy;
  assign w_step = (r_state == StRect) && !w_scan_done && !w_abort;

  sprite_rect_scan u_scan (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_step (w_step),
    .i_w_m1 (wr_data[F_W_LSB +: COORD_W]),
    .i_h_m1 (wr_data[F_H_LSB +: COORD_W]),
    .o_done (w_scan_done),
    .o_x    (w_off_x),
    .o_y    (w_off_y)
  );

  // One extra bit keeps the carry so clipping can see x0+i > 31.
  assign w_sum_x = {1'b0, r_x0} + {1'b0, w_off_x};
  assign w_sum_y = {1'b0, r_y0} + {1'b0, w_off_y};

`ifdef SPRITE_WR_CLIP_EN
  assign w_pix_on = !(w_sum_x[COORD_W] || w_sum_y[COORD_W]);
`else
  logic w_unused_carry;
  assign w_unused_carry = w_sum_x[COORD_W] ^ w_sum_y[COORD_W];
  assign w_pix_on       = 1'b1;
`endif

  assign w_unused_wdata = ^wr_data[31:22];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
    end else begin
      if (w_busy && (w_cmd_pix || w_cmd_rect)) begin
        r_err <= 1'b1;
      end else if (w_clr_err) begin
        r_err <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          r_we <= 1'b0;
          if (w_cmd_pix) begin
            r_state <= StPix;
            r_we    <= 1'b1;
            r_addr  <= ADDR_WIDTH'({wr_data[F_Y_LSB +: COORD_W], wr_data[F_X_LSB +: COORD_W]});
            r_din   <= DATA_WIDTH'(wr_data[F_PIX_COL_LSB +: COL_W]);
          end else if (w_cmd_rect) begin
            // First pixel (offset 0,0) is emitted straight from the command word.
            r_state <= StRect;
            r_we    <= 1'b1;
            r_addr  <= ADDR_WIDTH'({wr_data[F_Y_LSB +: COORD_W], wr_data[F_X_LSB +: COORD_W]});
            r_din   <= DATA_WIDTH'(wr_data[F_RECT_COL_LSB +: COL_W]);
            r_x0    <= wr_data[F_X_LSB +: COORD_W];
            r_y0    <= wr_data[F_Y_LSB +: COORD_W];
          end
        end
        StPix: begin
          r_state <= StIdle;
          r_we    <= 1'b0;
        end
        StRect: begin
          if (w_abort || w_scan_done) begin
            r_state <= StIdle;
            r_we    <= 1'b0;
          end else begin
            r_we   <= w_pix_on;
            r_addr <= ADDR_WIDTH'({w_sum_y[COORD_W-1:0], w_sum_x[COORD_W-1:0]});
          end
        end
        default: begin
          r_state <= StIdle;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign we     = r_we;
  assign addr_w = r_addr;
  assign din    = r_din;

  always_comb begin
    rd_data = '0;
    if (cs && read && (addr == OFF_STATUS)) begin
      rd_data = {30'b0, r_err, w_busy};
    end
  end

endmodule

// File: tb/tb_sprite_ram_writer.sv
module tb_sprite_ram_writer;

  logic        clk = 1'b0;
  logic        reset, cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        we;
  logic [9:0]  addr_w;
  logic [1:0]  din;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  sprite_ram_writer #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .we      (we),
    .addr_w  (addr_w),
    .din     (din)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rect_cmd(input int x0, input int y0, input int w, input int h,
                                           input int col);
    return 32'((x0 & 31) | ((y0 & 31) << 5) | (((w - 1) & 31) << 10) |
               (((h - 1) & 31) << 15) | ((col & 3) << 20));
  endfunction

  // Called at a falling edge; presents the write for one rising edge.
  task automatic bus_write(input logic [4:0] off, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = off; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
  endtask

  task automatic bus_read(input logic [4:0] off, output logic [31:0] v);
    cs = 1'b1; read = 1'b1; addr = off;
    #1;
    v = rd_data;
    cs = 1'b0; read = 1'b0; addr = '0;
  endtask

  logic [31:0] st;
  int          exp_rect[6] = '{196, 197, 198, 228, 229, 230};
  int          exp_clip_addr[4] = '{30, 31, 0, 1};
`ifdef SPRITE_WR_CLIP_EN
  logic        exp_clip_we[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
  logic        exp_clip_we[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(addr_w), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    bus_read(5'd2, st);
    check("rst_status", st, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single pixel x=1 y=2 colour=3.
    bus_write(5'd0, 32'h0000_0C41);
    check("pix_we", 32'(we), 32'd1);
    check("pix_addr", 32'(addr_w), 32'd65);
    check("pix_din", 32'(din), 32'd3);
    bus_read(5'd2, st);
    check("pix_busy", st, 32'd1);
    @(negedge clk);
    check("pix_we_off", 32'(we), 32'd0);
    bus_read(5'd2, st);
    check("pix_idle", st, 32'd0);

    // Rectangle 3x2 at (4,6), colour 2.
    bus_write(5'd1, rect_cmd(4, 6, 3, 2, 2));
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rect_we%0d", k), 32'(we), 32'd1);
      check($sformatf("rect_addr%0d", k), 32'(addr_w), 32'(exp_rect[k]));
      check($sformatf("rect_din%0d", k), 32'(din), 32'd2);
      @(negedge clk);
    end
    check("rect_we_end", 32'(we), 32'd0);
    bus_read(5'd2, st);
    check("rect_idle", st, 32'd0);
    @(negedge clk);

    // Second RECT while busy is dropped and flags err.
    bus_write(5'd1, rect_cmd(4, 6, 3, 2, 2));
    for (int k = 0; k < 6; k++) begin
      check($sformatf("err_we%0d", k), 32'(we), 32'd1);
      check($sformatf("err_addr%0d", k), 32'(addr_w), 32'(exp_rect[k]));
      check($sformatf("err_din%0d", k), 32'(din), 32'd2);
      if (k == 0) bus_write(5'd1, rect_cmd(0, 0, 8, 8, 1));
      else @(negedge clk);
    end
    check("err_we_end", 32'(we), 32'd0);
    bus_read(5'd2, st);
    check("err_status", st, 32'd2);
    bus_read(5'd1, st);
    check("rd_other_off", st, 32'd0);
    @(negedge clk);
    bus_write(5'd3, 32'h2);
    bus_read(5'd2, st);
    check("err_cleared", st, 32'd0);
    @(negedge clk);

    // Rectangle crossing the right edge: wrap or clip depending on build.
    bus_write(5'd1, rect_cmd(30, 0, 4, 1, 1));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("clip_we%0d", k), 32'(we), 32'(exp_clip_we[k]));
      if (exp_clip_we[k]) check($sformatf("clip_addr%0d", k), 32'(addr_w), 32'(exp_clip_addr[k]));
      bus_read(5'd2, st);
      check($sformatf("clip_busy%0d", k), st, 32'd1);
      @(negedge clk);
    end
    check("clip_we_end", 32'(we), 32'd0);
    bus_read(5'd2, st);
    check("clip_idle", st, 32'd0);
    @(negedge clk);

    // Abort a full-sprite fill during its third pixel.
    bus_write(5'd1, rect_cmd(0, 0, 32, 32, 1));
    repeat (2) @(negedge clk);
    check("abort_addr3", 32'(addr_w), 32'd2);
    bus_write(5'd3, 32'h1);
    check("abort_we", 32'(we), 32'd0);
    bus_read(5'd2, st);
    check("abort_status", st, 32'd0);
    bus_write(5'd0, 32'h0000_0465); // x=5 y=3 colour=1
    check("post_abort_we", 32'(we), 32'd1);
    check("post_abort_addr", 32'(addr_w), 32'd101);
    check("post_abort_din", 32'(din), 32'd1);
    @(negedge clk);

    // Reset in the middle of a fill, with err also set.
    bus_write(5'd1, rect_cmd(0, 0, 32, 32, 3));
    bus_write(5'd0, 32'h0000_0000);
    bus_read(5'd2, st);
    check("pre_rst_status", st, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_we", 32'(we), 32'd0);
    check("mid_rst_addr", 32'(addr_w), 32'd0);
    check("mid_rst_din", 32'(din), 32'd0);
    bus_read(5'd2, st);
    check("mid_rst_status", st, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_we%0d", k), 32'(we), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_ram_writer.md
SPRITE_RAM_WRITER -- requirements
Module: sprite_ram_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning the sprite RAM address width; sprite is 2**(ADDR_WIDTH/2) pixels square (32x32).
REQ-002 SHALL have parameter DATA_WIDTH, default 2, meaning the colour depth per pixel.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cs  input  1  slot select from the MMIO bus.
REQ-006 read  input  1  bus read strobe (qualified by cs).
REQ-007 write  input  1  bus write strobe (qualified by cs).
REQ-008 addr  input  5  register offset.
REQ-009 wr_data  input  32  bus write data.
REQ-010 rd_data  output  32  bus read data, combinational from registers.
REQ-011 we  output  1  sprite RAM write enable.
REQ-012 addr_w  output  ADDR_WIDTH  sprite RAM write address, y*32+x.
REQ-013 din  output  DATA_WIDTH  sprite RAM write data.

Function
REQ-014 Offset 0 write (PIXEL) SHALL write one pixel: x=wr_data[4:0], y=wr_data[9:5], colour=wr_data[11:10]; we is high exactly one cycle, the cycle after the bus write.
REQ-015 Offset 1 write (RECT) SHALL start a fill: x0=[4:0], y0=[9:5], w-1=[14:10], h-1=[19:15], colour=[21:20].
REQ-016 The FSM SHALL have states IDLE, PIX, RECT; IDLE->PIX on accepted PIXEL, PIX->IDLE after one cycle; IDLE->RECT on accepted RECT, RECT->IDLE after the last pixel cycle.
REQ-017 RECT SHALL emit one pixel per cycle in raster order (x fastest, then y), starting the cycle after the bus write, for exactly w*h cycles.
REQ-018 busy SHALL be high in PIX and RECT; it goes low the cycle after the last we cycle.
REQ-019 A PIXEL or RECT write while busy SHALL be ignored and SHALL set the sticky err flag.
REQ-020 Offset 2 read (STATUS) SHALL return {30'b0, err, busy}.
REQ-021 Offset 3 write (CTRL): wr_data[0]=1 aborts any operation (return to IDLE, we low next cycle); wr_data[1]=1 clears err.
REQ-022 Abort and a new command in the same cycle are impossible (one offset per cycle); abort in IDLE SHALL have no effect.
REQ-023 Coordinate arithmetic SHALL be 5 bits per axis; addr_w = {y, x}.
REQ-024 rd_data SHALL be 0 for offsets other than 2.

Reset
REQ-025 On reset the FSM SHALL enter IDLE; we=0, addr_w=0, din=0, busy=0, err=0, regardless of any operation in progress.

Configuration
REQ-026 With SPRITE_WR_CLIP_EN defined, RECT pixels whose x0+i or y0+j exceeds 31 SHALL keep we low for that cycle (cycle still consumed; total duration unchanged).
REQ-027 Without SPRITE_WR_CLIP_EN, x and y SHALL wrap modulo 32 and every rectangle cycle SHALL assert we.

Structure
REQ-028 A package sprite_pkg SHALL hold register offsets (PIXEL, RECT, STATUS, CTRL), command field bit positions, the state enum typedef, and sprite side length.
REQ-029 The x/y raster counter SHALL be a sub-module sprite_rect_scan (load, step, done, x, y outputs).

Verification
REQ-030 PIXEL write 0x00000C41 (x=1,y=2,colour=3) -> next cycle we=1, addr_w=65, din=3; following cycle we=0, busy=0.
REQ-031 RECT x0=4,y0=6,w=3,h=2,colour=2 -> 6 consecutive we cycles, addr_w 196,197,198,228,229,230, din=2; busy low on the 7th cycle.
REQ-032 RECT during busy -> ignored, original fill completes unchanged, STATUS reads 0x2 afterwards; CTRL write 0x2 -> STATUS reads 0x0.
REQ-033 RECT x0=30,y0=0,w=4,h=1 -> with SPRITE_WR_CLIP_EN: we on addr 30,31 only, 4 cycles busy; without: addr 30,31,0,1.
REQ-034 CTRL abort (0x1) in 3rd cycle of a 32x32 fill -> we low from next cycle, busy=0, new PIXEL accepted.
REQ-035 Reset asserted mid-RECT -> we=0, busy=0, err=0 on the next edge; no further writes.
